// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the seven-segment scan driver.
//   SEG_A..SEG_G : bit positions of each segment inside a {a,b,c,d,e,f,g}
//                  vector (a is the MSB, g the LSB).
//   S_A..S_G     : single-segment masks built from those positions.
//   GLYPH_DEC    : glyphs for codes 0..15 using the legacy 74x46 set.
//   GLYPH_HEX    : hex A..F glyphs for codes 10..15.
//   glyph()      : nibble + hex_mode -> segment vector (active-high).
// ---------------------------------------------------------------------------
package seg7_pkg;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    localparam logic [6:0] S_A = 7'(1 << SEG_A);
    localparam logic [6:0] S_B = 7'(1 << SEG_B);
    localparam logic [6:0] S_C = 7'(1 << SEG_C);
    localparam logic [6:0] S_D = 7'(1 << SEG_D);
    localparam logic [6:0] S_E = 7'(1 << SEG_E);
    localparam logic [6:0] S_F = 7'(1 << SEG_F);
    localparam logic [6:0] S_G = 7'(1 << SEG_G);

    localparam logic [6:0] GLYPH_DEC [0:15] = '{
        S_A | S_B | S_C | S_D | S_E | S_F,        // 0
        S_B | S_C,                                // 1
        S_A | S_B | S_D | S_E | S_G,              // 2
        S_A | S_B | S_C | S_D | S_G,              // 3
        S_B | S_C | S_F | S_G,                    // 4
        S_A | S_C | S_D | S_F | S_G,              // 5
        S_C | S_D | S_E | S_F | S_G,              // 6 (no top bar, 74x46 style)
        S_A | S_B | S_C,                          // 7
        S_A | S_B | S_C | S_D | S_E | S_F | S_G,  // 8
        S_A | S_B | S_C | S_F | S_G,              // 9 (no bottom bar)
        S_D | S_E | S_G,                          // 10
        S_C | S_D | S_G,                          // 11
        S_B | S_F | S_G,                          // 12
        S_A | S_D | S_F | S_G,                    // 13
        S_D | S_E | S_F | S_G,                    // 14
        7'h00                                     // 15 is dark
    };

    localparam logic [6:0] GLYPH_HEX [10:15] = '{
        S_A | S_B | S_C | S_E | S_F | S_G,        // A
        S_C | S_D | S_E | S_F | S_G,              // b
        S_A | S_D | S_E | S_F,                    // C
        S_B | S_C | S_D | S_E | S_G,              // d
        S_A | S_D | S_E | S_F | S_G,              // E
        S_A | S_E | S_F | S_G                     // F
    };

    function automatic logic [6:0] glyph(input logic [3:0] nibble, input logic hex_mode);
        logic [6:0] result;
        result = GLYPH_DEC[nibble];
        if (hex_mode && (nibble >= 4'd10)) begin
            result = GLYPH_HEX[nibble];
        end
        return result;
    endfunction

endpackage

// File: rtl/seg7_glyph.sv
// ---------------------------------------------------------------------------
// seg7_glyph
// Combinational nibble-to-segment decoder.
//   nibble   in  4  code to display
//   hex_mode in  1  0 = legacy 74x46 glyphs for 10..15, 1 = hex A..F
//   seg      out 7  {a,b,c,d,e,f,g}, active-high
// ---------------------------------------------------------------------------
module seg7_glyph
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       hex_mode,
    output logic [6:0] seg
);

    assign seg = glyph(nibble, hex_mode);

endmodule

// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed driver for a DIGITS-wide seven-segment display. A packed
// nibble vector and per-digit decimal points are latched on load, then one
// digit is driven per PRESCALE-cycle slot. The first GUARD cycles of every
// slot keep all digit enables off so the previous digit's segments never
// ghost onto the next one.
//   clk        in  1         system clock
//   rst        in  1         asynchronous active-high reset
//   value      in  4*DIGITS  nibble i drives digit i (digit 0 least significant)
//   dp_in      in  DIGITS    decimal point per digit
//   load       in  1         latch value and dp_in on this edge
//   blank_lz   in  1         blank leading zeros (digit 0 always shown)
//   lamp_test  in  1         force every segment and dp on
//   seg        out 7         {a,b,c,d,e,f,g}, registered, pin polarity
//   dp         out 1         decimal point, registered, pin polarity
//   dig        out DIGITS    one-hot digit enable, registered, pin polarity
// ---------------------------------------------------------------------------
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int PRESCALE       = 1024,
    parameter int GUARD          = 2,
    parameter bit HEX_MODE       = 1'b0,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit DIG_ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  blank_lz,
    input  logic                  lamp_test,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     dig
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0]  GUARD_CNT = CNT_W'(GUARD);

    // Inactive pin levels; the output registers reset to these.
    localparam logic [6:0]        SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic              DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [DIGITS-1:0] DIG_OFF = DIG_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] val_q, val_d;
    logic [DIGITS-1:0]   dp_q, dp_d;
    logic [6:0]          seg_out_q, seg_out_d;
    logic                dp_out_q, dp_out_d;
    logic [DIGITS-1:0]   dig_out_q, dig_out_d;

    logic [3:0]          sel_nibble;
    logic                sel_dp;
    logic                sel_blank;
    logic [DIGITS-1:0]   lz_mask;
    logic                zero_above;
    logic [6:0]          glyph_seg;
    logic                slot_on;
    logic [6:0]          seg_act;
    logic                dp_act;
    logic [DIGITS-1:0]   dig_act;

    // Prescaler and digit index: idx advances on the last cycle of a slot.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    always_comb begin
        val_d = load ? value : val_q;
        dp_d  = load ? dp_in : dp_q;
    end

    // Digit i (i > 0) is a leading zero when it and every more significant
    // nibble are zero; scan from the top down accumulating that condition.
    always_comb begin
        zero_above = 1'b1;
        lz_mask    = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above & (val_q[4*i +: 4] == 4'd0);
            lz_mask[i] = zero_above && (i != 0);
        end
    end

    always_comb begin
        sel_nibble = '0;
        sel_dp     = 1'b0;
        sel_blank  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_nibble = val_q[4*i +: 4];
                sel_dp     = dp_q[i];
                sel_blank  = lz_mask[i];
            end
        end
    end

    seg7_glyph u_glyph (
        .nibble   (sel_nibble),
        .hex_mode (HEX_MODE),
        .seg      (glyph_seg)
    );

    // A zero guard would make the comparison constant-true, so it is elided.
    generate
        if (GUARD == 0) begin : g_no_guard
            assign slot_on = 1'b1;
        end else begin : g_guard
            assign slot_on = (cnt_q >= GUARD_CNT);
        end
    endgenerate

    // Priority lamp test > leading-zero blank > glyph, then pin polarity.
    always_comb begin
        seg_act = glyph_seg;
        dp_act  = sel_dp;
        if (lamp_test) begin
            seg_act = 7'h7F;
            dp_act  = 1'b1;
        end else if (blank_lz && sel_blank) begin
            seg_act = 7'h00;
        end
        dig_act   = slot_on ? (DIGITS'(1) << idx_q) : '0;
        seg_out_d = seg_act ^ {7{SEG_ACTIVE_LOW}};
        dp_out_d  = dp_act ^ SEG_ACTIVE_LOW;
        dig_out_d = dig_act ^ {DIGITS{DIG_ACTIVE_LOW}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            val_q     <= '0;
            dp_q      <= '0;
            seg_out_q <= SEG_OFF;
            dp_out_q  <= DP_OFF;
            dig_out_q <= DIG_OFF;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            val_q     <= val_d;
            dp_q      <= dp_d;
            seg_out_q <= seg_out_d;
            dp_out_q  <= dp_out_d;
            dig_out_q <= dig_out_d;
        end
    end

    assign seg = seg_out_q;
    assign dp  = dp_out_q;
    assign dig = dig_out_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_driver
// Three driver instances share one stimulus stream:
//   u_a : 4 digits, 8-cycle slots, guard 2, legacy glyphs, active-high pins
//   u_b : 4 digits, 8-cycle slots, guard 2, hex glyphs, active-low pins
//   u_c : 1 digit, 3-cycle slots, no guard, hex glyphs
// The reference model derives slot and digit from the number of clock edges
// since reset release, and glyphs from the segment letter lists.
// ---------------------------------------------------------------------------
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        load;
    logic        blank_lz;
    logic        lamp_test;

    logic [6:0] seg_a, seg_b, seg_c;
    logic       dp_a, dp_b, dp_c;
    logic [3:0] dig_a, dig_b;
    logic [0:0] dig_c;

    always #5 clk = ~clk;

    seg7_scan_driver #(.DIGITS(4), .PRESCALE(8), .GUARD(2), .HEX_MODE(1'b0),
                       .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)) u_a (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load),
        .blank_lz(blank_lz), .lamp_test(lamp_test),
        .seg(seg_a), .dp(dp_a), .dig(dig_a));

    seg7_scan_driver #(.DIGITS(4), .PRESCALE(8), .GUARD(2), .HEX_MODE(1'b1),
                       .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) u_b (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load),
        .blank_lz(blank_lz), .lamp_test(lamp_test),
        .seg(seg_b), .dp(dp_b), .dig(dig_b));

    seg7_scan_driver #(.DIGITS(1), .PRESCALE(3), .GUARD(0), .HEX_MODE(1'b1),
                       .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)) u_c (
        .clk(clk), .rst(rst), .value(value[3:0]), .dp_in(dp_in[0:0]), .load(load),
        .blank_lz(blank_lz), .lamp_test(lamp_test),
        .seg(seg_c), .dp(dp_c), .dig(dig_c));

    // Per-instance configuration seen by the model.
    int CD [3] = '{4, 4, 1};
    int CP [3] = '{8, 8, 3};
    int CG [3] = '{2, 2, 0};
    bit CH [3] = '{1'b0, 1'b1, 1'b1};
    bit CSL[3] = '{1'b0, 1'b1, 1'b0};
    bit CDL[3] = '{1'b0, 1'b1, 1'b0};

    string DEC_S[16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "cdefg", "abc",
                         "abcdefg", "abcfg", "deg", "cdg", "bfg", "adfg", "defg", ""};
    string HEX_S[6]  = '{"abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    int          n_vec = 0;
    int          n_err = 0;
    int          m_n;      // clock edges seen since reset release
    logic [15:0] m_val;
    logic [3:0]  m_dp;

    logic [6:0] exp_seg [3];
    logic       exp_dp  [3];
    logic [7:0] exp_dig [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, want %h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [6:0] ref_glyph(input int code, input bit hx);
        string      s;
        logic [6:0] r;
        s = (hx && code >= 10) ? HEX_S[code - 10] : DEC_S[code];
        r = '0;
        for (int i = 0; i < s.len(); i++) begin
            r[6 - (int'(s.getc(i)) - 97)] = 1'b1;
        end
        return r;
    endfunction

    function automatic void model(input int k);
        int          d, p, idx, code;
        logic [15:0] v;
        logic [6:0]  s;
        logic        o;
        logic [7:0]  g;
        d = CD[k];
        p = CP[k];
        v = (d == 1) ? {12'h000, m_val[3:0]} : m_val;
        s = '0;
        o = 1'b0;
        g = '0;
        if (!rst) begin
            idx  = (m_n / p) % d;
            code = int'((v >> (4 * idx)) & 16'h000F);
            if ((m_n % p) >= CG[k]) g = 8'(1 << idx);
            s = ref_glyph(code, CH[k]);
            o = m_dp[idx];
            if (lamp_test) begin
                s = 7'h7F;
                o = 1'b1;
            end else if (blank_lz && idx > 0 && (v >> (4 * idx)) == 16'h0) begin
                s = 7'h00;
            end
        end
        if (CSL[k]) begin
            s = ~s;
            o = ~o;
        end
        if (CDL[k]) g = ~g & 8'((1 << d) - 1);
        exp_seg[k] = s;
        exp_dp[k]  = o;
        exp_dig[k] = g;
    endfunction

    task automatic compare_all();
        chk("a.seg", 32'(seg_a), 32'(exp_seg[0]));
        chk("a.dp",  32'(dp_a),  32'(exp_dp[0]));
        chk("a.dig", 32'(dig_a), 32'(exp_dig[0]));
        chk("b.seg", 32'(seg_b), 32'(exp_seg[1]));
        chk("b.dp",  32'(dp_b),  32'(exp_dp[1]));
        chk("b.dig", 32'(dig_b), 32'(exp_dig[1]));
        chk("c.seg", 32'(seg_c), 32'(exp_seg[2]));
        chk("c.dp",  32'(dp_c),  32'(exp_dp[2]));
        chk("c.dig", 32'(dig_c), 32'(exp_dig[2]));
    endtask

    // One clock edge: predict from pre-edge state, advance the model, compare.
    task automatic step();
        for (int k = 0; k < 3; k++) model(k);
        @(posedge clk);
        #1;
        if (rst) begin
            m_n   = 0;
            m_val = '0;
            m_dp  = '0;
        end else begin
            m_n++;
            if (load) begin
                m_val = value;
                m_dp  = dp_in;
            end
        end
        compare_all();
    endtask

    initial begin
        rst       = 1'b0;
        value     = '0;
        dp_in     = '0;
        load      = 1'b0;
        blank_lz  = 1'b0;
        lamp_test = 1'b0;
        m_n       = 0;
        m_val     = '0;
        m_dp      = '0;

        // Asynchronous reset, checked before any clock edge.
        #1 rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) model(k);
        compare_all();
        repeat (2) step();
        rst = 1'b0;

        // Leading-zero blanking with a dp on a blanked digit.
        value = 16'h0070; dp_in = 4'b1000; blank_lz = 1'b1; load = 1'b1;
        step();
        load = 1'b0;
        repeat (40) step();
        value = 16'h0000; load = 1'b1;
        step();
        load = 1'b0;
        repeat (34) step();

        // Lamp test over a full frame, then release.
        lamp_test = 1'b1;
        repeat (32) step();
        lamp_test = 1'b0;
        repeat (8) step();

        // Glyph sweep across all codes.
        blank_lz = 1'b0;
        for (int code = 0; code < 16; code++) begin
            value = {4{4'(code)}};
            dp_in = 4'(code);
            load  = 1'b1;
            step();
            load = 1'b0;
            repeat (32) step();
        end

        // Load on the edge where the digit index wraps 3 -> 0.
        while ((m_n % 32) != 31) step();
        value = 16'h1234; dp_in = 4'b0000; load = 1'b1;
        step();
        load = 1'b0;
        repeat (40) step();

        // Reset asserted mid-slot clears the outputs without a clock edge.
        repeat (5) step();
        #3 rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) model(k);
        compare_all();
        repeat (2) step();
        rst = 1'b0;

        // Random traffic.
        repeat (600) begin
            value     = 16'($urandom);
            dp_in     = 4'($urandom);
            load      = ($urandom_range(0, 7) == 0);
            blank_lz  = 1'($urandom);
            lamp_test = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
